// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the feature/weight RAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int RAM_ADDR_W = 18;
  localparam int RAM_DATA_W = 16;

  // Requester index width; a single-bit index is kept even for tiny configurations.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_priority_picker
  import ram_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o
);

  logic [IDW:0]   sum_s;
  logic [IDW-1:0] cand_s;
  logic           found_s;

  // Scan NUM_REQ candidates starting at the pointer, keep the first requester.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    found_s = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_i} + (IDW+1)'(k);
      if (sum_s >= (IDW+1)'(NUM_REQ)) begin
        sum_s = sum_s - (IDW+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IDW-1:0];
      if (!found_s && req_i[cand_s]) begin
        gnt_o[cand_s] = 1'b1;
        idx_o         = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM, with locked bursts and tagged read return.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 3,
  parameter  int ADDR_W    = RAM_ADDR_W,
  parameter  int DATA_W    = RAM_DATA_W,
  parameter  int MAX_BURST = 16,
  localparam int IDW       = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rvalid,
  output logic [IDW-1:0]            rid,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic                      mem_we,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int             BW         = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0]  BURST_LAST = BW'(MAX_BURST - 1);
  localparam bit             BURST_EN   = (MAX_BURST > 1);

  arb_state_e          state_q;
  logic [IDW-1:0]      rr_ptr_q;
  logic [IDW-1:0]      owner_q;
  logic [BW-1:0]       burst_cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic [IDW-1:0]      rid_q;

  logic [NUM_REQ-1:0]  pick_gnt_s;
  logic [IDW-1:0]      pick_idx_s;
  logic [NUM_REQ-1:0]  gnt_s;
  logic [IDW-1:0]      gidx_s;
  logic                any_gnt_s;
  logic [IDW-1:0]      ptr_after_s;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i (req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt_s),
    .idx_o (pick_idx_s)
  );

  // Grant selection: free arbitration in ARB, owner-only while LOCKED.
  always_comb begin
    gnt_s  = '0;
    gidx_s = '0;
    if (state_q == ST_LOCKED) begin
      gnt_s[owner_q] = req[owner_q];
      gidx_s         = owner_q;
    end else begin
      gnt_s  = pick_gnt_s;
      gidx_s = pick_idx_s;
    end
    any_gnt_s = |gnt_s;
    if (gidx_s == IDW'(NUM_REQ - 1)) begin
      ptr_after_s = '0;
    end else begin
      ptr_after_s = gidx_s + IDW'(1);
    end
  end

  // RAM pin mux; writes are suppressed outright while reset is asserted.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (any_gnt_s) begin
      mem_addr  = addr[gidx_s*ADDR_W +: ADDR_W];
      mem_wdata = wdata[gidx_s*DATA_W +: DATA_W];
      mem_we    = we[gidx_s] & rst_n;
    end else begin
      mem_we    = 1'b0;
    end
  end

  // Arbitration FSM plus registered read return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ARB;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      rid_q       <= '0;
    end else begin
      if (any_gnt_s && !we[gidx_s]) begin
        rdata_q  <= mem_rdata;
        rid_q    <= gidx_s;
        rvalid_q <= 1'b1;
      end else begin
        rvalid_q <= 1'b0;
      end
      case (state_q)
        ST_ARB: begin
          if (any_gnt_s) begin
            if (BURST_EN && lock[gidx_s]) begin
              owner_q     <= gidx_s;
              burst_cnt_q <= BW'(1);
              state_q     <= ST_LOCKED;
            end else begin
              rr_ptr_q <= ptr_after_s;
            end
          end else begin
            state_q <= ST_ARB;
          end
        end
        ST_LOCKED: begin
          // Dropped request, final access, or burst cap all hand the pointer past the owner.
          if (!req[owner_q] || !lock[owner_q] || (burst_cnt_q == BURST_LAST)) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= ptr_after_s;
          end else begin
            burst_cnt_q <= burst_cnt_q + BW'(1);
          end
        end
        default: begin
          state_q <= ST_ARB;
        end
      endcase
    end
  end

  assign gnt    = gnt_s;
  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rid    = rid_q;

endmodule
